// File: rtl/godai_trace_pkg.sv
// Shared definitions for the trace recorder: record type codes, record field
// widths and the default parameter values used by the recorder and its FIFO.
package godai_trace_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_TS_WIDTH   = 16;

    // Low-order record fields: type[1:0] followed by the taken bit.
    localparam int TYPE_W  = 2;
    localparam int TAKEN_W = 1;
    localparam int META_W  = TYPE_W + TAKEN_W;

    localparam int DROP_W  = 16;

    typedef enum logic [TYPE_W-1:0] {
        REC_NONE     = 2'b00,
        REC_BRANCH   = 2'b01,
        REC_JUMP     = 2'b10,
        REC_REDIRECT = 2'b11
    } rec_type_e;

endpackage

// File: rtl/godai_trace_fifo.sv
// Synchronous record FIFO for the trace recorder.
// Ports:
//   clk, rst_n     - clock and asynchronous active-low reset (pointers only)
//   push, wr_data  - write request and record to store
//   pop            - read request; removes the head record
//   rd_data        - head record, forced to zero while empty
//   full, empty    - occupancy flags
// A push while full is accepted only when a pop happens in the same cycle.
module godai_trace_fifo
    import godai_trace_pkg::*;
#(
    parameter int DATA_W = DEF_TS_WIDTH + DEF_ADDR_WIDTH + META_W,
    parameter int DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    // Extra MSB on each pointer separates full from empty when indices match.
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_en;
    logic              rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    // Storage holds data only; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[PTR_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Masking keeps the output at zero after reset instead of stale storage.
    assign rd_data = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/godai_trace_recorder.sv
// Instruction trace recorder: watches the core's fetch and control-flow
// signals, forms one timestamped record per cycle and buffers it for a
// valid/ready consumer.
// Ports:
//   clk, rst_n                 - clock and asynchronous active-low reset
//   enable_i                   - record capture enable
//   instr_req_i, instr_gnt_i,
//   instr_addr_i               - fetch handshake; granted address is latched
//   branch_req_i, branch_decision_i, jump_done_i, pc_set_i,
//   is_decoding_i, id_ready_i  - control-flow event sources
//   trace_valid_o, trace_ready_i, trace_data_o
//                              - record stream {timestamp, addr, type, taken}
//   overflow_o                 - sticky flag: a record was lost
//   drop_count_o               - saturating count of lost records
module godai_trace_recorder
    import godai_trace_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int TS_WIDTH   = DEF_TS_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable_i,
    input  logic                           instr_req_i,
    input  logic                           instr_gnt_i,
    input  logic [ADDR_WIDTH-1:0]          instr_addr_i,
    input  logic                           branch_req_i,
    input  logic                           branch_decision_i,
    input  logic                           jump_done_i,
    input  logic                           pc_set_i,
    input  logic                           is_decoding_i,
    input  logic                           id_ready_i,
    output logic                           trace_valid_o,
    input  logic                           trace_ready_i,
    output logic [TS_WIDTH+ADDR_WIDTH+2:0] trace_data_o,
    output logic                           overflow_o,
    output logic [DROP_W-1:0]              drop_count_o
);

    localparam int REC_W = TS_WIDTH + ADDR_WIDTH + META_W;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == {DROP_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    logic [TS_WIDTH-1:0]   ts_p0;
    logic [ADDR_WIDTH-1:0] fetch_addr_p0;

    logic       branch_evt;
    logic       any_evt;
    rec_type_e  rec_type_p0;
    logic       rec_taken_p0;
    logic [REC_W-1:0] rec_p0;

    logic fifo_full;
    logic fifo_empty;
    logic fifo_push;
    logic fifo_pop;
    logic rec_drop;

    // Stage p0: event decode and record formation in the event cycle.
    assign branch_evt = branch_req_i && is_decoding_i && id_ready_i;
    assign any_evt    = branch_evt || jump_done_i || pc_set_i;

    // Only the highest-priority event of a cycle becomes a record.
    always_comb begin
        rec_type_p0  = REC_NONE;
        rec_taken_p0 = 1'b1;
        if (branch_evt) begin
            rec_type_p0  = REC_BRANCH;
            rec_taken_p0 = branch_decision_i;
        end else if (jump_done_i) begin
            rec_type_p0 = REC_JUMP;
        end else if (pc_set_i) begin
            rec_type_p0 = REC_REDIRECT;
        end
    end

    // Address comes from the register, i.e. the last grant before this edge.
    assign rec_p0 = {ts_p0, fetch_addr_p0, rec_type_p0, rec_taken_p0};

    assign fifo_pop  = trace_valid_o && trace_ready_i;
    assign fifo_push = enable_i && any_evt && (!fifo_full || fifo_pop);
    assign rec_drop  = enable_i && any_evt && fifo_full && !fifo_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_p0         <= '0;
            fetch_addr_p0 <= '0;
            overflow_o    <= 1'b0;
            drop_count_o  <= '0;
        end else begin
            ts_p0 <= ts_p0 + 1'b1;
            if (instr_req_i && instr_gnt_i) begin
                fetch_addr_p0 <= instr_addr_i;
            end
            if (rec_drop) begin
                overflow_o   <= 1'b1;
                drop_count_o <= sat_inc(drop_count_o);
            end
        end
    end

    // Stage p1: buffered records presented to the consumer.
    godai_trace_fifo #(
        .DATA_W (REC_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (rec_p0),
        .rd_data (trace_data_o),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign trace_valid_o = !fifo_empty;

endmodule

// File: tb/tb_godai_trace_recorder.sv
// Scoreboard bench for godai_trace_recorder: a behavioural model turns each
// cycle's inputs into expected records held in a queue; a monitor compares
// every record the DUT hands over, plus the status outputs, against it.
module tb_godai_trace_recorder;

    localparam int AW = 32;
    localparam int D  = 8;
    localparam int TW = 16;
    localparam int RW = TW + AW + 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable_i;
    logic          instr_req_i;
    logic          instr_gnt_i;
    logic [AW-1:0] instr_addr_i;
    logic          branch_req_i;
    logic          branch_decision_i;
    logic          jump_done_i;
    logic          pc_set_i;
    logic          is_decoding_i;
    logic          id_ready_i;
    logic          trace_valid_o;
    logic          trace_ready_i;
    logic [RW-1:0] trace_data_o;
    logic          overflow_o;
    logic [15:0]   drop_count_o;

    always #5 clk = ~clk;

    godai_trace_recorder #(
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (D),
        .TS_WIDTH   (TW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .enable_i          (enable_i),
        .instr_req_i       (instr_req_i),
        .instr_gnt_i       (instr_gnt_i),
        .instr_addr_i      (instr_addr_i),
        .branch_req_i      (branch_req_i),
        .branch_decision_i (branch_decision_i),
        .jump_done_i       (jump_done_i),
        .pc_set_i          (pc_set_i),
        .is_decoding_i     (is_decoding_i),
        .id_ready_i        (id_ready_i),
        .trace_valid_o     (trace_valid_o),
        .trace_ready_i     (trace_ready_i),
        .trace_data_o      (trace_data_o),
        .overflow_o        (overflow_o),
        .drop_count_o      (drop_count_o)
    );

    // Reference model state
    int            m_cnt;
    logic [TW-1:0] m_ts;
    logic [AW-1:0] m_addr;
    logic [15:0]   m_drops;
    logic          m_ovf;
    logic [RW-1:0] exp_q [$];

    // Monitor state
    int            rd_idx;
    int            n_cmp;
    int            n_bad;
    bit            final_done;
    bit            stall_prev;
    logic [RW-1:0] data_prev;

    // Driver state
    bit            final_req;

    // Model: evaluated on each rising edge from the inputs held during the cycle.
    always @(posedge clk) begin
        bit         pop_m;
        bit         push_m;
        bit         br;
        logic [1:0] ty;
        logic       tk;
        if (!rst_n) begin
            m_cnt   = 0;
            m_ts    = '0;
            m_addr  = '0;
            m_drops = '0;
            m_ovf   = 1'b0;
        end else begin
            pop_m  = (m_cnt > 0) && trace_ready_i;
            push_m = 1'b0;
            br     = branch_req_i && is_decoding_i && id_ready_i;
            if (enable_i && (br || jump_done_i || pc_set_i)) begin
                if (br) begin
                    ty = 2'b01; tk = branch_decision_i;
                end else if (jump_done_i) begin
                    ty = 2'b10; tk = 1'b1;
                end else begin
                    ty = 2'b11; tk = 1'b1;
                end
                if (m_cnt < D || pop_m) begin
                    exp_q.push_back({m_ts, m_addr, ty, tk});
                    push_m = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                    if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
                end
            end
            m_cnt = m_cnt + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
            if (instr_req_i && instr_gnt_i) m_addr = instr_addr_i;
            m_ts = m_ts + 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid", 64'(trace_valid_o), 64'd0);
            chk("rst_data", 64'(trace_data_o), 64'd0);
            chk("rst_drops", 64'(drop_count_o), 64'd0);
            chk("rst_overflow", 64'(overflow_o), 64'd0);
            rd_idx     = exp_q.size();
            stall_prev = 1'b0;
        end else begin
            chk("valid", 64'(trace_valid_o), 64'(m_cnt > 0));
            chk("drop_count", 64'(drop_count_o), 64'(m_drops));
            chk("overflow", 64'(overflow_o), 64'(m_ovf));
            if (stall_prev && trace_valid_o)
                chk("stall_stable", 64'(trace_data_o), 64'(data_prev));
            if (trace_valid_o && trace_ready_i) begin
                if (rd_idx < exp_q.size()) begin
                    chk("record", 64'(trace_data_o), 64'(exp_q[rd_idx]));
                    rd_idx++;
                end else begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL record_unexpected: got %0h expected none", trace_data_o);
                end
            end
            stall_prev = trace_valid_o && !trace_ready_i;
            data_prev  = trace_data_o;
            if (final_req && !final_done) begin
                chk("leftover_records", 64'(rd_idx), 64'(exp_q.size()));
                final_done = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_events();
        instr_req_i       = 1'b0;
        instr_gnt_i       = 1'b0;
        branch_req_i      = 1'b0;
        branch_decision_i = 1'b0;
        jump_done_i       = 1'b0;
        pc_set_i          = 1'b0;
        is_decoding_i     = 1'b0;
        id_ready_i        = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        enable_i      = 1'b1;
        trace_ready_i = 1'b1;
        instr_addr_i  = '0;
        final_req     = 1'b0;
        clear_events();
        repeat (3) tick();
        rst_n = 1'b1;

        // Fetch 0x100 granted, branch taken at ts=5.
        instr_req_i = 1'b1; instr_gnt_i = 1'b1; instr_addr_i = 32'h100;
        tick();
        clear_events();
        repeat (4) tick();
        branch_req_i = 1'b1; is_decoding_i = 1'b1; id_ready_i = 1'b1; branch_decision_i = 1'b1;
        tick();
        clear_events();
        repeat (3) tick();

        // Coincident branch, jump and redirect.
        branch_req_i = 1'b1; is_decoding_i = 1'b1; id_ready_i = 1'b1;
        jump_done_i = 1'b1; pc_set_i = 1'b1;
        tick();
        clear_events();
        repeat (3) tick();

        // Ten jumps with consumer stalled: eight kept, two dropped.
        trace_ready_i = 1'b0;
        jump_done_i = 1'b1;
        repeat (10) tick();
        jump_done_i = 1'b0;
        tick();

        // Full FIFO: event and pop together.
        trace_ready_i = 1'b1; jump_done_i = 1'b1;
        tick();
        jump_done_i = 1'b0; trace_ready_i = 1'b0;
        tick();
        trace_ready_i = 1'b1;
        repeat (10) tick();

        // Capture disabled while earlier records drain.
        trace_ready_i = 1'b0; jump_done_i = 1'b1;
        repeat (3) tick();
        jump_done_i = 1'b0;
        enable_i = 1'b0; trace_ready_i = 1'b1;
        pc_set_i = 1'b1; tick(); pc_set_i = 1'b0;
        jump_done_i = 1'b1; tick(); jump_done_i = 1'b0;
        branch_req_i = 1'b1; is_decoding_i = 1'b1; id_ready_i = 1'b1; tick();
        clear_events();
        repeat (5) tick();
        enable_i = 1'b1;

        // Reset with four records buffered.
        trace_ready_i = 1'b0; jump_done_i = 1'b1;
        repeat (4) tick();
        jump_done_i = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        trace_ready_i = 1'b1;
        repeat (3) tick();

        // Randomized traffic with varying consumer throughput.
        for (int i = 0; i < 2000; i++) begin
            int rdy_pct;
            rdy_pct           = ((i / 200) % 3 == 0) ? 20 : 80;
            enable_i          = ($urandom_range(0, 7) != 0);
            instr_req_i       = $urandom_range(0, 1) == 1;
            instr_gnt_i       = $urandom_range(0, 1) == 1;
            instr_addr_i      = $urandom();
            branch_req_i      = $urandom_range(0, 3) == 0;
            branch_decision_i = $urandom_range(0, 1) == 1;
            is_decoding_i     = $urandom_range(0, 3) != 0;
            id_ready_i        = $urandom_range(0, 3) != 0;
            jump_done_i       = $urandom_range(0, 4) == 0;
            pc_set_i          = $urandom_range(0, 5) == 0;
            trace_ready_i     = $urandom_range(0, 99) < rdy_pct;
            rst_n             = !(i >= 1000 && i < 1002);
            tick();
        end

        // Drain everything still buffered.
        rst_n = 1'b1;
        enable_i = 1'b1;
        clear_events();
        trace_ready_i = 1'b1;
        repeat (20) tick();
        final_req = 1'b1;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
